priority_resolver_ctrl: RTL

//  Upstream stage of the in-service register. Latches IR0-IR7 into the IRR, resolves the highest-priority

---
 rtl/pic_pkg.sv | 28 ++
 rtl/rot_priority_encoder.sv | 26 ++
 rtl/priority_resolver_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt priority resolver: FSM states, OCW2 command codes, index width.
package pic_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SET_ISR,
        ST_WAIT2,
        ST_VECTOR
    } pic_state_e;

    // OCW2[7:5] command field
    localparam logic [2:0] OCW2_AEOI_CLR  = 3'b000;
    localparam logic [2:0] OCW2_AEOI_SET  = 3'b100;
    localparam logic [2:0] OCW2_NS_ROTATE = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO  = 3'b110;
    localparam logic [2:0] OCW2_SP_ROTATE = 3'b111;

    // Distance of idx from the current highest-priority slot; smaller means higher priority.
    function automatic logic [IDX_W-1:0] prio_dist(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] start);
        return idx - start;
    endfunction

endpackage

// File: rtl/rot_priority_encoder.sv
// Rotating priority encoder: first set bit of vec_i scanning upward from start_i, wrapping 7->0.
module rot_priority_encoder
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] vec_i,
    input  logic [IDX_W-1:0]  start_i,
    output logic              found_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int unsigned i = 0; i < NUM_IR; i++) begin
            pos = start_i + IDX_W'(i);
            if (!found_o && vec_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/priority_resolver_ctrl.sv
// IRR capture, rotating-priority arbitration against the ISR, and the two-pulse INTA handshake.
// Optional feature macro: SPECIAL_MASK_EN (special mask mode masks in-service levels by imr).
module priority_resolver_ctrl
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] irLines,
    input  logic              levelTriggered,
    input  logic [NUM_IR-1:0] imr,
    input  logic [NUM_IR-1:0] isrValue,
    input  logic              intaN,
    input  logic              ocw2Strobe,
    input  logic [7:0]        ocw2,
    input  logic              eoi,
    input  logic [IDX_W-1:0]  resetedIndex,
    input  logic              readPriorityAck,
    input  logic              sendVectorAck,
    input  logic              smm,
    output logic              intReq,
    output logic [IDX_W-1:0]  toSet,
    output logic              readPriority,
    output logic              sendVector,
    output logic              secondACK,
    output logic [IDX_W-1:0]  zeroLevelIndex,
    output logic [NUM_IR-1:0] irrValue
);

    pic_state_e        state_q;
    logic              int_req_q, rp_q, sv_q, sa_q, spurious_q;
    logic [IDX_W-1:0]  to_set_q;
    logic              rp_shadow_q, sv_shadow_q;

    logic [NUM_IR-1:0] irr_q, irr_d, ir_prev_q;
    logic              inta_prev_q, eoi_prev_q;
    logic [IDX_W-1:0]  zero_q, zero_d;
    logic              aeoi_q, aeoi_d, nsrot_q, nsrot_d;

    logic [NUM_IR-1:0] isr_eff, ack_clr;
    logic              cand_found, isr_found, cand_valid;
    logic [IDX_W-1:0]  cand_idx, isr_idx;
    logic              inta_fall, eoi_rise, freeze;
    logic              unused_ok;

`ifdef SPECIAL_MASK_EN
    assign isr_eff   = smm ? (isrValue & ~imr) : isrValue;
    assign unused_ok = ^ocw2[4:3];
`else
    assign isr_eff   = isrValue;
    assign unused_ok = ^{smm, ocw2[4:3]};
`endif

    rot_priority_encoder u_irr_enc (
        .vec_i   (irr_q & ~imr),
        .start_i (zero_q),
        .found_o (cand_found),
        .idx_o   (cand_idx)
    );

    rot_priority_encoder u_isr_enc (
        .vec_i   (isr_eff),
        .start_i (zero_q),
        .found_o (isr_found),
        .idx_o   (isr_idx)
    );

    // A request equal to the top in-service level is not strictly ahead, so it stays blocked.
    assign cand_valid = cand_found &&
                        (!isr_found || (prio_dist(cand_idx, zero_q) < prio_dist(isr_idx, zero_q)));

    assign inta_fall = inta_prev_q & ~intaN;
    assign eoi_rise  = eoi & ~eoi_prev_q;
    assign freeze    = (state_q == ST_REQ) && inta_fall && cand_valid;
    assign ack_clr   = freeze ? ({{(NUM_IR-1){1'b0}}, 1'b1} << cand_idx) : '0;

    always_comb begin
        if (levelTriggered) begin
            irr_d = irLines & ~ack_clr;
        end else begin
            irr_d = (irr_q & ~ack_clr) | (irLines & ~ir_prev_q);
        end
    end

    // An OCW2 write takes precedence over an EOI edge arriving in the same cycle.
    always_comb begin
        zero_d  = zero_q;
        aeoi_d  = aeoi_q;
        nsrot_d = nsrot_q;
        if (ocw2Strobe) begin
            unique case (ocw2[7:5])
                OCW2_NS_ROTATE:                nsrot_d = 1'b1;
                OCW2_SP_ROTATE, OCW2_SET_PRIO: zero_d  = ocw2[2:0] + 3'd1;
                OCW2_AEOI_SET:                 aeoi_d  = 1'b1;
                OCW2_AEOI_CLR:                 aeoi_d  = 1'b0;
                default:                       ;
            endcase
        end else if (eoi_rise && (aeoi_q || nsrot_q)) begin
            zero_d  = resetedIndex + 3'd1;
            nsrot_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irr_q       <= '0;
            ir_prev_q   <= irLines;
            inta_prev_q <= intaN;
            eoi_prev_q  <= eoi;
            zero_q      <= '0;
            aeoi_q      <= 1'b0;
            nsrot_q     <= 1'b0;
        end else begin
            irr_q       <= irr_d;
            ir_prev_q   <= irLines;
            inta_prev_q <= intaN;
            eoi_prev_q  <= eoi;
            zero_q      <= zero_d;
            aeoi_q      <= aeoi_d;
            nsrot_q     <= nsrot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            int_req_q   <= 1'b0;
            to_set_q    <= '0;
            rp_q        <= 1'b0;
            sv_q        <= 1'b0;
            sa_q        <= 1'b0;
            spurious_q  <= 1'b0;
            rp_shadow_q <= readPriorityAck;
            sv_shadow_q <= sendVectorAck;
        end else begin
            rp_q <= 1'b0;
            sv_q <= 1'b0;
            sa_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cand_valid) begin
                        int_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (inta_fall) begin
                        int_req_q <= 1'b0;
                        if (cand_valid) begin
                            to_set_q   <= cand_idx;
                            rp_q       <= 1'b1;
                            spurious_q <= 1'b0;
                            state_q    <= ST_SET_ISR;
                        end else begin
                            to_set_q   <= '1;
                            spurious_q <= 1'b1;
                            state_q    <= ST_WAIT2;
                        end
                    end
                end
                ST_SET_ISR: begin
                    if (readPriorityAck != rp_shadow_q) begin
                        rp_shadow_q <= readPriorityAck;
                        state_q     <= ST_WAIT2;
                    end
                end
                ST_WAIT2: begin
                    if (inta_fall) begin
                        sv_q    <= 1'b1;
                        sa_q    <= ~spurious_q;
                        state_q <= ST_VECTOR;
                    end
                end
                ST_VECTOR: begin
                    if (sendVectorAck != sv_shadow_q) begin
                        sv_shadow_q <= sendVectorAck;
                        spurious_q  <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign intReq         = int_req_q;
    assign toSet          = to_set_q;
    assign readPriority   = rp_q;
    assign sendVector     = sv_q;
    assign secondACK      = sa_q;
    assign zeroLevelIndex = zero_q;
    assign irrValue       = irr_q;

endmodule
